uart_rx_sampler: RTL and testbench

- Serial receive stage directly downstream of the FCB baud generator.
- Detects the start-bit falling edge on the serial input and drives the baud generator's counter-clear input to phase-align it.
- Uses the generator's mid-period strobe (Baud_rate_re) to sample start, data, optional parity and stop bits.
- Presents each received word on a valid/ready interface with per-word error flags.

---
 rtl/uart_rx_sampler_if.sv | 27 ++
 rtl/uart_rx_sampler.sv | 128 ++++++++++++
 tb/tb_uart_rx_sampler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Received-word handshake bundle between the UART sampler (master) and its consumer (slave).
// Carries the word, its error flags, valid and ready.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Rx_data_o;
    logic                 Rx_valid_o;
    logic                 Rx_ready_i;
    logic                 Parity_err_o;
    logic                 Frame_err_o;

    modport master (
        output Rx_data_o,
        output Rx_valid_o,
        output Parity_err_o,
        output Frame_err_o,
        input  Rx_ready_i
    );

    modport slave (
        input  Rx_data_o,
        input  Rx_valid_o,
        input  Parity_err_o,
        input  Frame_err_o,
        output Rx_ready_i
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: start-edge detect, baud-generator phase align, mid-bit sampling of start/data/parity/stop.
// Latency: word valid one clock after the stop-bit strobe; the start edge is seen SYNC_STAGES+1 clocks after Rx_i falls.
// Backpressure: one-word holding register; a word completing while the previous one is unaccepted is dropped and flags overrun.
module uart_rx_sampler #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Bus_Clk_i,
    input  logic              RST_i,
    input  logic              Rx_i,
    input  logic              Baud_rate_re_i,
    output logic              smc_clear_br_cnt_o,
    input  logic              Parity_en_i,
    input  logic              Parity_odd_i,
    uart_rx_sampler_if.master rx_if,
    output logic              Overrun_o,
    input  logic              Overrun_clr_i,
    output logic              Busy_o
);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s, rx_prev;
    logic                 start_edge, last_bit;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q, par_odd_q, par_err_q;
    logic                 clear_d, cnt_clr, shift_en, par_smp, word_done;
    logic                 accept, load_word;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = ~rx_s & rx_prev;
    assign last_bit   = (bit_cnt == CW'(DATA_BITS - 1));

    always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], Rx_i};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_edge) state_d = S_START;
            S_START:  if (Baud_rate_re_i) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (Baud_rate_re_i && last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (Baud_rate_re_i) state_d = S_STOP;
            S_STOP:   if (Baud_rate_re_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clear_d   = (state_q == S_IDLE)   && start_edge;
        cnt_clr   = (state_q == S_START)  && Baud_rate_re_i;
        shift_en  = (state_q == S_DATA)   && Baud_rate_re_i;
        par_smp   = (state_q == S_PARITY) && Baud_rate_re_i;
        word_done = (state_q == S_STOP)   && Baud_rate_re_i;
    end

    assign accept    = rx_if.Rx_valid_o & rx_if.Rx_ready_i;
    assign load_word = word_done & (~rx_if.Rx_valid_o | rx_if.Rx_ready_i);
    assign Busy_o    = (state_q != S_IDLE);

    always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i) begin
            smc_clear_br_cnt_o <= 1'b0;
            par_en_q           <= 1'b0;
            par_odd_q          <= 1'b0;
            par_err_q          <= 1'b0;
            bit_cnt            <= '0;
            shift_q            <= '0;
        end else begin
            smc_clear_br_cnt_o <= clear_d;
            // Line format is frozen at the start edge so mid-frame changes cannot corrupt it.
            if (clear_d) begin
                par_en_q  <= Parity_en_i;
                par_odd_q <= Parity_odd_i;
                par_err_q <= 1'b0;
            end
            if (cnt_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + CW'(1);
            if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (par_smp)  par_err_q <= rx_s ^ (^shift_q) ^ par_odd_q;
        end
    end

    always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i) begin
            rx_if.Rx_data_o    <= '0;
            rx_if.Rx_valid_o   <= 1'b0;
            rx_if.Parity_err_o <= 1'b0;
            rx_if.Frame_err_o  <= 1'b0;
            Overrun_o          <= 1'b0;
        end else begin
            if (load_word) begin
                rx_if.Rx_data_o    <= shift_q;
                rx_if.Rx_valid_o   <= 1'b1;
                rx_if.Parity_err_o <= par_en_q & par_err_q;
                rx_if.Frame_err_o  <= ~rx_s;
            end else if (accept) begin
                rx_if.Rx_valid_o   <= 1'b0;
                rx_if.Parity_err_o <= 1'b0;
                rx_if.Frame_err_o  <= 1'b0;
            end
            if (word_done && !load_word) Overrun_o <= 1'b1;
            else if (Overrun_clr_i)      Overrun_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler with a behavioural baud generator (Divisor = 4, 8 clocks per bit).
module tb_uart_rx_sampler;
    localparam int DIV = 4;
    localparam int BIT_CLKS = 2 * DIV;

    logic Bus_Clk_i = 1'b0;
    logic RST_i = 1'b1;
    logic Rx_i = 1'b1;
    logic Baud_rate_re_i;
    logic smc_clear_br_cnt_o;
    logic Parity_en_i = 1'b0;
    logic Parity_odd_i = 1'b0;
    logic Overrun_o;
    logic Overrun_clr_i = 1'b0;
    logic Busy_o;
    logic [7:0] br_cnt;
    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;

    uart_rx_sampler_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_sampler #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .Bus_Clk_i          (Bus_Clk_i),
        .RST_i              (RST_i),
        .Rx_i               (Rx_i),
        .Baud_rate_re_i     (Baud_rate_re_i),
        .smc_clear_br_cnt_o (smc_clear_br_cnt_o),
        .Parity_en_i        (Parity_en_i),
        .Parity_odd_i       (Parity_odd_i),
        .rx_if              (rx_if),
        .Overrun_o          (Overrun_o),
        .Overrun_clr_i      (Overrun_clr_i),
        .Busy_o             (Busy_o)
    );

    always #5 Bus_Clk_i = ~Bus_Clk_i;

    // Baud generator: strobe Divisor+1 clocks after a clear, then every 2*Divisor clocks.
    always @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i)                         br_cnt <= 8'd0;
        else if (smc_clear_br_cnt_o)       br_cnt <= 8'd0;
        else if (br_cnt == BIT_CLKS - 1)   br_cnt <= 8'd0;
        else                               br_cnt <= br_cnt + 8'd1;
    end
    assign Baud_rate_re_i = (br_cnt == DIV);

    always @(posedge Bus_Clk_i) if (!RST_i && smc_clear_br_cnt_o) clr_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge Bus_Clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb);
        Rx_i = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            Rx_i = d[i];
            clks(BIT_CLKS);
        end
        if (pen) begin
            Rx_i = pbit;
            clks(BIT_CLKS);
        end
        Rx_i = stopb;
        clks(BIT_CLKS);
        Rx_i = 1'b1;
    endtask

    task automatic accept_word();
        rx_if.Rx_ready_i = 1'b1;
        clks(1);
        rx_if.Rx_ready_i = 1'b0;
    endtask

    initial begin
        rx_if.Rx_ready_i = 1'b0;
        clks(3);
        chk("rst_valid", {31'd0, rx_if.Rx_valid_o}, 32'd0);
        chk("rst_data", {24'd0, rx_if.Rx_data_o}, 32'd0);
        chk("rst_flags", {30'd0, rx_if.Parity_err_o, rx_if.Frame_err_o}, 32'd0);
        chk("rst_ovr_busy_clr", {29'd0, Overrun_o, Busy_o, smc_clear_br_cnt_o}, 32'd0);
        RST_i = 1'b0;
        clks(5);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        clks(1);
        chk("a5_valid", {31'd0, rx_if.Rx_valid_o}, 32'd1);
        chk("a5_data", {24'd0, rx_if.Rx_data_o}, 32'hA5);
        chk("a5_flags", {30'd0, rx_if.Parity_err_o, rx_if.Frame_err_o}, 32'd0);
        chk("a5_busy", {31'd0, Busy_o}, 32'd0);
        chk("a5_clr_pulses", clr_pulses, 32'd1);
        accept_word();
        chk("accept_valid", {31'd0, rx_if.Rx_valid_o}, 32'd0);

        // Even parity, 0x03 with wrong then right parity bit
        Parity_en_i = 1'b1;
        Parity_odd_i = 1'b0;
        clks(4);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        clks(1);
        chk("par1_data", {24'd0, rx_if.Rx_data_o}, 32'h03);
        chk("par1_perr", {31'd0, rx_if.Parity_err_o}, 32'd1);
        accept_word();
        chk("par1_acc_perr", {31'd0, rx_if.Parity_err_o}, 32'd0);
        clks(4);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        clks(1);
        chk("par0_valid", {31'd0, rx_if.Rx_valid_o}, 32'd1);
        chk("par0_perr", {31'd0, rx_if.Parity_err_o}, 32'd0);
        accept_word();
        Parity_en_i = 1'b0;

        // 3-clock glitch: false start
        clks(4);
        Rx_i = 1'b0;
        clks(3);
        Rx_i = 1'b1;
        clks(30);
        chk("glitch_clr_pulses", clr_pulses, 32'd4);
        chk("glitch_valid", {31'd0, rx_if.Rx_valid_o}, 32'd0);
        chk("glitch_busy", {31'd0, Busy_o}, 32'd0);

        // Back-to-back frames with no consumer: overrun
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        clks(1);
        chk("ovr_data", {24'd0, rx_if.Rx_data_o}, 32'h11);
        chk("ovr_valid", {31'd0, rx_if.Rx_valid_o}, 32'd1);
        chk("ovr_set", {31'd0, Overrun_o}, 32'd1);
        Overrun_clr_i = 1'b1;
        clks(1);
        Overrun_clr_i = 1'b0;
        chk("ovr_clr", {31'd0, Overrun_o}, 32'd0);

        // Consumer ready exactly in the completion cycle
        clks(4);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        rx_if.Rx_ready_i = 1'b1;
        clks(1);
        rx_if.Rx_ready_i = 1'b0;
        chk("same_cyc_data", {24'd0, rx_if.Rx_data_o}, 32'h22);
        chk("same_cyc_valid", {31'd0, rx_if.Rx_valid_o}, 32'd1);
        chk("same_cyc_ovr", {31'd0, Overrun_o}, 32'd0);
        accept_word();

        // Stop bit low, then a clean frame
        clks(4);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        clks(1);
        chk("ferr_data", {24'd0, rx_if.Rx_data_o}, 32'h5A);
        chk("ferr_set", {31'd0, rx_if.Frame_err_o}, 32'd1);
        clks(8);
        accept_word();
        clks(4);
        send_frame(8'h5B, 1'b0, 1'b0, 1'b1);
        clks(1);
        chk("ferr_next_data", {24'd0, rx_if.Rx_data_o}, 32'h5B);
        chk("ferr_next_clear", {31'd0, rx_if.Frame_err_o}, 32'd0);

        // Reset during the 4th data bit while a word is held
        clks(4);
        Rx_i = 1'b0;
        clks(BIT_CLKS * 4 + DIV);
        chk("pre_rst_busy", {31'd0, Busy_o}, 32'd1);
        RST_i = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, rx_if.Rx_valid_o}, 32'd0);
        chk("mid_rst_data", {24'd0, rx_if.Rx_data_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, Busy_o}, 32'd0);
        Rx_i = 1'b1;
        clks(3);
        RST_i = 1'b0;
        clks(5);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        clks(1);
        chk("post_rst_valid", {31'd0, rx_if.Rx_valid_o}, 32'd1);
        chk("post_rst_data", {24'd0, rx_if.Rx_data_o}, 32'hC3);
        chk("post_rst_flags", {29'd0, rx_if.Parity_err_o, rx_if.Frame_err_o, Overrun_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
